// File: rtl/datapath_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_fsm
// Purpose  : Instruction sequencer for the lab5 datapath. Accepts one
//            instruction per start/ready handshake and steps the datapath
//            through register read, execute and writeback, one stage per
//            clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high
//   start        in   1       instruction request, accepted when ready=1
//   op           in   3       000 MOVI,001 MOV,010 ADD,011 CMP,100 AND,101 MVN
//   rd/rn/rm     in   3 each  destination / operand A / operand B registers
//   sh           in   2       shift code applied to operand B in EXEC
//   imm8         in   IMM_W   immediate for MOVI
//   readnum      out  3       register-file read index
//   writenum     out  3       register-file write index
//   write,vsel,loada,loadb,asel,bsel,loadc,loads  out 1 each
//   shift,ALUop  out  2 each
//   datapath_in  out  DATA_W  zero-extended latched immediate
//   ready        out  1       high only in IDLE
//   done         out  1       one-cycle pulse on the first IDLE cycle after
//                             an instruction completes
//   err          out  1       pulses with done for an invalid op
// ============================================================================
module datapath_ctrl_fsm #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [2:0]        rd,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [1:0]        sh,
    input  logic [IMM_W-1:0]  imm8,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              vsel,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic              loadc,
    output logic              loads,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] datapath_in,
    output logic              ready,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] c_OP_MOVI = 3'b000;
    localparam logic [2:0] c_OP_MOV  = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_CMP  = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_MVN  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_A    = 3'd1,
        S_LOAD_B    = 3'd2,
        S_EXEC      = 3'd3,
        S_WRITE_IMM = 3'd4,
        S_WRITE_REG = 3'd5
    } state_t;

    state_t             r_state;

    // Latched instruction fields. rn is only needed in LOAD_A, which always
    // directly follows acceptance, so it is consumed straight from the input.
    logic [2:0]         r_op;
    logic [2:0]         r_rd;
    logic [2:0]         r_rm;
    logic [1:0]         r_sh;

    // Registered Moore outputs: each transition loads the control word that
    // belongs to the state being entered.
    logic [2:0]         r_readnum;
    logic [2:0]         r_writenum;
    logic               r_write;
    logic               r_vsel;
    logic               r_loada;
    logic               r_loadb;
    logic               r_asel;
    logic               r_loadc;
    logic               r_loads;
    logic [1:0]         r_shift;
    logic [1:0]         r_aluop;
    logic [DATA_W-1:0]  r_dp_in;
    logic               r_ready;
    logic               r_done;
    logic               r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= 3'b000;
            r_rd       <= 3'b000;
            r_rm       <= 3'b000;
            r_sh       <= 2'b00;
            r_readnum  <= 3'b000;
            r_writenum <= 3'b000;
            r_write    <= 1'b0;
            r_vsel     <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_asel     <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_shift    <= 2'b00;
            r_aluop    <= 2'b00;
            r_dp_in    <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Every control is zero unless the state being entered sets it.
            r_readnum  <= 3'b000;
            r_writenum <= 3'b000;
            r_write    <= 1'b0;
            r_vsel     <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_asel     <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_shift    <= 2'b00;
            r_aluop    <= 2'b00;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_rd    <= rd;
                        r_rm    <= rm;
                        r_sh    <= sh;
                        r_dp_in <= DATA_W'(imm8);
                        case (op)
                            c_OP_MOVI: begin
                                r_state    <= S_WRITE_IMM;
                                r_writenum <= rd;
                                r_vsel     <= 1'b1;
                                r_write    <= 1'b1;
                            end
                            c_OP_MOV, c_OP_MVN: begin
                                r_state   <= S_LOAD_B;
                                r_readnum <= rm;
                                r_loadb   <= 1'b1;
                            end
                            c_OP_ADD, c_OP_CMP, c_OP_AND: begin
                                r_state   <= S_LOAD_A;
                                r_readnum <= rn;
                                r_loada   <= 1'b1;
                            end
                            default: begin
                                // Invalid op completes immediately with an
                                // error flag and never leaves IDLE.
                                r_state <= S_IDLE;
                                r_ready <= 1'b1;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end

                S_LOAD_A: begin
                    r_state   <= S_LOAD_B;
                    r_readnum <= r_rm;
                    r_loadb   <= 1'b1;
                end

                S_LOAD_B: begin
                    r_state <= S_EXEC;
                    r_shift <= r_sh;
                    r_loadc <= 1'b1;
                    case (r_op)
                        // MOV passes B through the adder with A forced to 0.
                        c_OP_MOV: begin
                            r_aluop <= 2'b00;
                            r_asel  <= 1'b1;
                        end
                        c_OP_ADD: r_aluop <= 2'b00;
                        c_OP_CMP: begin
                            // Compare only updates status; C is left alone.
                            r_aluop <= 2'b01;
                            r_loads <= 1'b1;
                            r_loadc <= 1'b0;
                        end
                        c_OP_AND: r_aluop <= 2'b10;
                        c_OP_MVN: r_aluop <= 2'b11;
                        default:  r_aluop <= 2'b00;
                    endcase
                end

                S_EXEC: begin
                    if (r_op == c_OP_CMP) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_WRITE_REG;
                        r_writenum <= r_rd;
                        r_write    <= 1'b1;
                    end
                end

                S_WRITE_IMM, S_WRITE_REG: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign readnum     = r_readnum;
    assign writenum    = r_writenum;
    assign write       = r_write;
    assign vsel        = r_vsel;
    assign loada       = r_loada;
    assign loadb       = r_loadb;
    assign asel        = r_asel;
    assign bsel        = 1'b0;      // shifted register B is always the B source
    assign loadc       = r_loadc;
    assign loads       = r_loads;
    assign shift       = r_shift;
    assign ALUop       = r_aluop;
    assign datapath_in = r_dp_in;
    assign ready       = r_ready;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_ctrl_fsm
// Purpose  : Self-checking bench for datapath_ctrl_fsm. A schedule-based
//            model predicts the full control word every cycle; directed
//            literal checks pin key cycles of each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b0, rd = 3'b0, rn = 3'b0, rm = 3'b0;
    logic [1:0]  sh = 2'b0;
    logic [7:0]  imm8 = 8'h0;
    logic [2:0]  readnum, writenum;
    logic        write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    logic        ready, done, err;

    int checks = 0;
    int failures = 0;

    datapath_ctrl_fsm #(.DATA_W(16), .IMM_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd), .rn(rn),
        .rm(rm), .sh(sh), .imm8(imm8), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel),
        .bsel(bsel), .loadc(loadc), .loads(loads), .shift(shift), .ALUop(ALUop),
        .datapath_in(datapath_in), .ready(ready), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Control word layout:
    // {readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads,
    //  shift, ALUop, ready, done, err}
    function automatic logic [20:0] vec(input logic [2:0] rdn, input logic [2:0] wrn,
                                        input logic wr, input logic vs, input logic la,
                                        input logic lb, input logic as, input logic lc,
                                        input logic ls, input logic [1:0] shf,
                                        input logic [1:0] alu, input logic rdy,
                                        input logic dn, input logic er);
        return {rdn, wrn, wr, vs, la, lb, as, 1'b0, lc, ls, shf, alu, rdy, dn, er};
    endfunction

    logic [20:0] w_dut_vec;
    assign w_dut_vec = {readnum, writenum, write, vsel, loada, loadb, asel, bsel,
                        loadc, loads, shift, ALUop, ready, done, err};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // On accept, the whole future of the instruction is written out as a list
    // of per-cycle control words ending with the done cycle.
    logic [20:0] m_idle;
    logic [20:0] m_cur;
    logic [15:0] m_dpin;
    logic [20:0] m_q[$];

    initial begin
        m_idle = vec(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0);
        m_cur  = m_idle;
        m_dpin = 16'h0;
    end

    task automatic m_build(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a,
                           input logic [2:0] b, input logic [1:0] s);
        bit two_src, is_cmp;
        logic [1:0] alu;
        logic as;
        if (o == 3'd0) begin
            m_q.push_back(vec(3'd0, d, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));
            m_q.push_back(vec(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 0));
        end else if (o >= 3'd6) begin
            m_q.push_back(vec(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 1));
        end else begin
            two_src = (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
            is_cmp  = (o == 3'd3);
            as      = (o == 3'd1);
            case (o)
                3'd3:    alu = 2'b01;
                3'd4:    alu = 2'b10;
                3'd5:    alu = 2'b11;
                default: alu = 2'b00;
            endcase
            if (two_src)
                m_q.push_back(vec(a, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));
            m_q.push_back(vec(b, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));
            m_q.push_back(vec(3'd0, 3'd0, 0, 0, 0, 0, as, !is_cmp, is_cmp, s, alu, 0, 0, 0));
            if (!is_cmp)
                m_q.push_back(vec(3'd0, d, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));
            m_q.push_back(vec(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 0));
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_cur  = m_idle;
            m_dpin = 16'h0;
        end else begin
            if (m_cur[2] && start) begin
                m_dpin = {8'h00, imm8};
                m_build(op, rd, rn, rm, sh);
            end
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else                m_cur = m_idle;
        end
    end

    always @(negedge clk) begin
        chk("ctrl_word", {11'd0, w_dut_vec}, {11'd0, m_cur});
        chk("datapath_in", {16'd0, datapath_in}, {16'd0, m_dpin});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a,
                         input logic [2:0] b, input logic [1:0] s, input logic [7:0] im);
        start = 1'b1; op = o; rd = d; rn = a; rm = b; sh = s; imm8 = im;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_dpin", {16'd0, datapath_in}, 32'h0);
        reset = 1'b0;
        tick();

        // MOVI rd=3 imm=0x2A
        issue(3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 8'h2A);
        chk("movi_write", {31'd0, write}, 32'd1);
        chk("movi_vsel", {31'd0, vsel}, 32'd1);
        chk("movi_writenum", {29'd0, writenum}, 32'd3);
        chk("movi_dpin", {16'd0, datapath_in}, 32'h002A);
        tick();
        chk("movi_done", {31'd0, done}, 32'd1);
        tick();
        chk("movi_done_once", {31'd0, done}, 32'd0);

        // ADD rd=2 rn=0 rm=1 sh=01
        issue(3'd2, 3'd2, 3'd0, 3'd1, 2'd1, 8'h55);
        chk("add_loada", {31'd0, loada}, 32'd1);
        chk("add_dpin", {16'd0, datapath_in}, 32'h0055);
        tick();
        chk("add_loadb_rn", {29'd0, readnum}, 32'd1);
        tick();
        chk("add_exec", {26'd0, shift, ALUop, loadc, loads}, {26'd0, 2'b01, 2'b00, 1'b1, 1'b0});
        tick();
        chk("add_wr", {28'd0, write, writenum}, {28'd0, 1'b1, 3'd2});
        tick();
        chk("add_done", {30'd0, done, ready}, 32'b11);

        // CMP rn=5 rm=5
        issue(3'd3, 3'd0, 3'd5, 3'd5, 2'd0, 8'h00);
        tick();
        tick();
        chk("cmp_exec", {28'd0, loads, loadc, ALUop}, {28'd0, 1'b1, 1'b0, 2'b01});
        tick();
        chk("cmp_done_nowrite", {30'd0, done, write}, 32'b10);

        // Invalid op
        issue(3'd7, 3'd1, 3'd2, 3'd3, 2'd2, 8'hF0);
        chk("inv_done_err", {30'd0, done, err}, 32'b11);
        chk("inv_no_ctrl", {31'd0, write | loada | loadb | loadc | loads}, 32'd0);
        tick();
        chk("inv_pulse_end", {30'd0, done, err}, 32'b00);

        // MOV rd=4 rm=6 with a stray start during LOAD_B
        issue(3'd1, 3'd4, 3'd0, 3'd6, 2'd0, 8'h00);
        chk("mov_loadb", {31'd0, loadb}, 32'd1);
        start = 1'b1; op = 3'd2;
        tick();
        start = 1'b0;
        chk("mov_exec_asel", {31'd0, asel}, 32'd1);
        tick();
        tick();
        chk("mov_done", {30'd0, done, ready}, 32'b11);
        tick();
        chk("mov_no_second", {30'd0, done, ready}, 32'b01);

        // start held high: MOVI re-accepted in its own done cycle
        start = 1'b1; op = 3'd0; rd = 3'd1; imm8 = 8'h11;
        tick();
        tick();
        imm8 = 8'h22; rd = 3'd6;
        chk("b2b_done_accept", {31'd0, done}, 32'd1);
        tick();
        start = 1'b0;
        chk("b2b_second", {16'd0, datapath_in}, 32'h0022);
        tick();
        tick();

        // AND reset mid-EXEC
        issue(3'd4, 3'd7, 3'd2, 3'd3, 2'd3, 8'h99);
        tick();
        tick();
        chk("and_exec", {29'd0, loadc, ALUop}, {29'd0, 1'b1, 2'b10});
        #1 reset = 1'b1;
        #1;
        chk("rst_async", {28'd0, loadc, ready, done, write}, 32'b0100);
        chk("rst_dpin", {16'd0, datapath_in}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_no_done", {30'd0, done, write}, 32'b00);

        // Sweep all ops through the model
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 3'(7 - i), 3'(i), 3'(i + 1), 2'(i), 8'(8'h30 + i));
            repeat (5) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
